soc_top_v1: RTL and testbench
=============================

Name: soc_top_v1

Overview:
- Board-level demo top for the 100 MHz FPGA board (16 switches, 4 buttons, 16 LEDs, 8-digit 7-segment display, 3 UART pairs).
- After reset it transmits "HOLA MUNDO\r\n" on UART A and shows "HOLA" plus live status on the display.
- It mirrors the switches on the LEDs, receives bytes on UART A, and loops UARTs B and C back.

Parameters:
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200).
- REFRESH_DIV, 100000, clock cycles each display digit stays active.

Ports:
- clk_100m_i  in  1  100 MHz system clock.
- rst_i  in  1  asynchronous, active-low reset.
- sw_bt_i  in  20  [15:0] switches, [19:16] buttons.
- rx_a_i  in  1  UART A serial input, idle high.
- rx_b_i  in  1  UART B serial input, idle high.
- rx_c_i  in  1  UART C serial input, idle high.
- leds_o  out  16  LEDs, active high.
- an_o  out  8  digit enables, active low, one-hot.
- seg_o  out  8  {dp,g,f,e,d,c,b,a}, active low.
- tx_a_o  out  1  UART A serial output.
- tx_b_o  out  1  UART B serial output.
- tx_c_o  out  1  UART C serial output.

Behaviour:
- Reset (rst_i=0, asynchronous): leds_o=0, an_o=8'hFF, seg_o=8'hFF, tx_*_o=1, rx byte register=8'h00, digit index=0, message pointer=0.
- Synchronisation: all asynchronous inputs (sw_bt_i, rx_*) pass through a 2-flop synchroniser.
- LEDs: leds_o = synchronised sw_bt_i[15:0], registered; latency 3 cycles.
- Loopback: tx_b_o and tx_c_o = synchronised rx_b_i and rx_c_i; latency 2 cycles.
- UART A transmit format: 8N1, LSB first, each bit exactly BAUD_DIV cycles.
- Message: 12 bytes 48 4F 4C 41 20 4D 55 4E 44 4F 0D 0A, sent back-to-back with no idle between stop bit and next start bit.
  - After the last stop bit the FSM goes IDLE and tx_a_o stays 1.
  - Auto-start: the first start bit begins within 4 cycles after rst_i rises.
- Message FSM: IDLE -> SEND (load byte[ptr]) -> WAIT_DONE -> ptr++. Goes to SEND again if ptr<12, else to IDLE.
- Replay: a rising edge of synchronised sw_bt_i[16] in IDLE restarts the message at ptr=0. Edges while sending are ignored. No debounce.
- UART A receive:
  - A falling edge on synchronised rx starts reception; the start bit is re-checked at BAUD_DIV/2.
  - 8 data bits are sampled at mid-bit and the stop bit is checked.
  - Stop bit = 1: byte stored to the rx byte register. Stop bit = 0: byte discarded.
  - Receiver is independent of the transmitter.
- Display scan:
  - Digit index increments every REFRESH_DIV cycles and wraps 7->0.
  - an_o bit[index] = 0, others 1; an_o and seg_o are registered.
  - Digits 7..4 show H, O, L, A.
    - H = segs b,c,e,f,g; O = a–f; L = d,e,f; A = a,b,c,e,f,g.
  - Digits 3..2 show the hex of the rx byte; digits 1..0 show the hex of sw_bt_i[7:0].
  - dp is always off (seg_o[7]=1).
- Hex glyphs use the standard a–g patterns (0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80, F = 8'h8E including dp).
- Reset mid-transmission: tx_a_o returns to 1 immediately. The message restarts from byte 0 after release.

Decomposition:
- Package soc_top_v1_pkg holds:
  - the 12-byte message ROM constant and MSG_LEN=12;
  - the glyph constants for H/O/L/A and the hex-to-7-segment function;
  - the FSM state enum.
- One natural sub-module: uart_tx_8n1 (inputs start and data, outputs busy and serial line).
- The receiver, scan, and synchronisers stay in the top.

Test Plan (BAUD_DIV=8, REFRESH_DIV=4):
- Hold rst_i=0, then release -> during reset all tx_*_o=1 and an_o=FF; after release tx_a_o emits 12 frames decoding to "HOLA MUNDO\r\n", 8 cycles per bit, no gaps, then stays 1.
- Set sw_bt_i=20'h0A5C3 -> leds_o=16'hA5C3 after 3 cycles; digits 1..0 show C (8'hC6) and 3 (8'hB0).
- Drive rx_a_i with frame 0x3C (valid stop) -> digits 3..2 show 3 (8'hB0) and C (8'hC6); a frame 0x55 with stop=0 leaves the display unchanged.
- Observe scan -> an_o cycles FE,FD,...,7F every 4 cycles; digit 7 seg_o=8'h89 (H), digit 4 seg_o=8'h88 (A).
- Toggle rx_b_i and rx_c_i -> tx_b_o and tx_c_o follow after 2 cycles.
- Pulse sw_bt_i[16] mid-message (ignored) and again in IDLE -> exactly one extra full message; assert rst_i=0 mid-frame -> tx_a_o=1 immediately.

Source files
------------

// File: rtl/soc_top_v1_pkg.sv
// Shared constants for the board demo top: greeting ROM, display glyphs,
// the hex-to-seven-segment decoder and the message sequencer states.
package soc_top_v1_pkg;

  localparam int MSG_LEN = 12;

  // Segment patterns are active low, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] GLYPH_H     = 8'h89;
  localparam logic [7:0] GLYPH_O     = 8'hC0;
  localparam logic [7:0] GLYPH_L     = 8'hC7;
  localparam logic [7:0] GLYPH_A     = 8'h88;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE
  } msg_state_t;

  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h48;
      4'd1:    b = 8'h4F;
      4'd2:    b = 8'h4C;
      4'd3:    b = 8'h41;
      4'd4:    b = 8'h20;
      4'd5:    b = 8'h4D;
      4'd6:    b = 8'h55;
      4'd7:    b = 8'h4E;
      4'd8:    b = 8'h44;
      4'd9:    b = 8'h4F;
      4'd10:   b = 8'h0D;
      4'd11:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/soc_top_v1_uart_tx_8n1.sv
// 8N1 serial transmitter, LSB first, BAUD_DIV clocks per bit. A start request
// held across the final stop-bit cycle is taken immediately, so frames chain with no idle gap.
module uart_tx_8n1
  import soc_top_v1_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          stop_end;
  logic          accept;
  logic          bit_end;

  // busy drops during the last stop-bit cycle so the next frame can be accepted on that edge
  assign stop_end = active && (bit_idx == 4'd9) && (baud_cnt == BAUD_LAST);
  assign busy     = active && !stop_end;
  assign accept   = start && !busy;
  assign bit_end  = active && (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else if (accept) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx      <= shreg[0];
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

  // Data bits then the stop bit; vacated positions fill with 1
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {1'b1, data};
    end else if (bit_end && (bit_idx != 4'd9)) begin
      shreg <= {1'b1, shreg[8:1]};
    end
  end

endmodule

// File: rtl/soc_top_v1.sv
// Board demo top: greets on UART A, receives bytes on UART A, loops UARTs B/C,
// mirrors switches on LEDs and scans "HOLA" plus rx byte and switch hex on the display.
module soc_top_v1
  import soc_top_v1_pkg::*;
#(
  parameter int BAUD_DIV    = 868,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk_100m_i,
  input  logic        rst_i,
  input  logic [19:0] sw_bt_i,
  input  logic        rx_a_i,
  input  logic        rx_b_i,
  input  logic        rx_c_i,
  output logic [15:0] leds_o,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        tx_a_o,
  output logic        tx_b_o,
  output logic        tx_c_o
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [3:0] PTR_LAST = 4'(MSG_LEN - 1);

  logic [16:0] sw_meta, sw_sync;
  logic [2:0]  rx_meta, rx_sync;
  logic        unused_buttons;

  // Buttons 19..17 have no function on this board build
  assign unused_buttons = ^sw_bt_i[19:17];

  // Two-flop synchronisers; serial lines idle high
  always_ff @(posedge clk_100m_i or negedge rst_i) begin
    if (!rst_i) begin
      sw_meta <= '0;
      sw_sync <= '0;
      rx_meta <= '1;
      rx_sync <= '1;
    end else begin
      sw_meta <= sw_bt_i[16:0];
      sw_sync <= sw_meta;
      rx_meta <= {rx_c_i, rx_b_i, rx_a_i};
      rx_sync <= rx_meta;
    end
  end

  assign tx_b_o = rx_sync[1];
  assign tx_c_o = rx_sync[2];

  always_ff @(posedge clk_100m_i or negedge rst_i) begin
    if (!rst_i) begin
      leds_o <= '0;
    end else begin
      leds_o <= sw_sync[15:0];
    end
  end

  msg_state_t state;
  logic [3:0] ptr;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       btn_prev;
  logic       btn_rise;

  assign btn_rise = sw_sync[16] && !btn_prev;

  // Reset lands in SEND so the greeting goes out without any button press
  always_ff @(posedge clk_100m_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_SEND;
      ptr      <= '0;
      tx_start <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= sw_sync[16];
      case (state)
        ST_IDLE: begin
          if (btn_rise) begin
            ptr   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_start && !tx_busy) begin
            tx_start <= 1'b0;
            state    <= ST_WAIT_DONE;
          end else begin
            tx_start <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          // Earlier bytes queue behind the running frame; the last one waits for its stop bit
          if ((ptr != PTR_LAST) || !tx_busy) begin
            ptr   <= ptr + 4'd1;
            state <= (ptr == PTR_LAST) ? ST_IDLE : ST_SEND;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100m_i) begin
    if (state == ST_SEND) begin
      tx_data <= msg_byte(ptr);
    end
  end

  uart_tx_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_a (
    .clk  (clk_100m_i),
    .rst_n(rst_i),
    .start(tx_start),
    .data (tx_data),
    .busy (tx_busy),
    .tx   (tx_a_o)
  );

  logic          rx_on;
  logic          rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          rx_sample;

  assign rx_sample = rx_on && (rx_cnt == '0);

  // rx_bit: 0 = start re-check, 1..8 = data, 9 = stop
  always_ff @(posedge clk_100m_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_on   <= 1'b0;
      rx_prev <= 1'b1;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_byte <= 8'h00;
    end else begin
      rx_prev <= rx_sync[0];
      if (!rx_on) begin
        if (rx_prev && !rx_sync[0]) begin
          rx_on  <= 1'b1;
          rx_cnt <= HALF_LAST;
          rx_bit <= '0;
        end
      end else if (!rx_sample) begin
        rx_cnt <= rx_cnt - CW'(1);
      end else begin
        rx_cnt <= BAUD_LAST;
        rx_bit <= rx_bit + 4'd1;
        if ((rx_bit == 4'd0) && rx_sync[0]) begin
          rx_on <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_on <= 1'b0;
          if (rx_sync[0]) begin
            rx_byte <= rx_shift;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_100m_i) begin
    if (rx_sample && (rx_bit != 4'd0) && (rx_bit != 4'd9)) begin
      rx_shift <= {rx_sync[0], rx_shift[7:1]};
    end
  end

  logic [RW-1:0] ref_cnt;
  logic [2:0]    digit;
  logic [7:0]    glyph;

  always_comb begin
    glyph = GLYPH_BLANK;
    case (digit)
      3'd7: glyph = GLYPH_H;
      3'd6: glyph = GLYPH_O;
      3'd5: glyph = GLYPH_L;
      3'd4: glyph = GLYPH_A;
      3'd3: glyph = hex_to_seg(rx_byte[7:4]);
      3'd2: glyph = hex_to_seg(rx_byte[3:0]);
      3'd1: glyph = hex_to_seg(sw_sync[7:4]);
      3'd0: glyph = hex_to_seg(sw_sync[3:0]);
    endcase
  end

  always_ff @(posedge clk_100m_i or negedge rst_i) begin
    if (!rst_i) begin
      ref_cnt <= '0;
      digit   <= '0;
      an_o    <= 8'hFF;
      seg_o   <= 8'hFF;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        digit   <= digit + 3'd1;
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end
      an_o  <= ~(8'd1 << digit);
      seg_o <= glyph;
    end
  end

endmodule

// File: tb/tb_soc_top_v1.sv
// Directed bench for soc_top_v1 with short baud and refresh divisors.
module tb_soc_top_v1;

  localparam int BAUD    = 8;
  localparam int REFRESH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] sw    = '0;
  logic        rx_a  = 1'b1;
  logic        rx_b  = 1'b1;
  logic        rx_c  = 1'b1;
  logic [15:0] leds;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        tx_a;
  logic        tx_b;
  logic        tx_c;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] msg [12] = '{8'h48, 8'h4F, 8'h4C, 8'h41, 8'h20, 8'h4D,
                           8'h55, 8'h4E, 8'h44, 8'h4F, 8'h0D, 8'h0A};
  logic [7:0] exp_seg [8] = '{8'hB0, 8'hC6, 8'hC6, 8'hB0, 8'h88, 8'hC7, 8'hC0, 8'h89};

  soc_top_v1 #(
    .BAUD_DIV   (BAUD),
    .REFRESH_DIV(REFRESH)
  ) dut (
    .clk_100m_i(clk),
    .rst_i     (rst_n),
    .sw_bt_i   (sw),
    .rx_a_i    (rx_a),
    .rx_b_i    (rx_b),
    .rx_c_i    (rx_c),
    .leds_o    (leds),
    .an_o      (an),
    .seg_o     (seg),
    .tx_a_o    (tx_a),
    .tx_b_o    (tx_b),
    .tx_c_o    (tx_c)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input int limit, output int waited, output logic found);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < limit) begin
      @(negedge clk);
      waited++;
      if (tx_a === 1'b0) found = 1'b1;
    end
  endtask

  // Caller is positioned on the first sample of the start bit
  task automatic grab_frame(output logic [7:0] b, output logic ok);
    logic first;
    logic v;
    ok    = 1'b1;
    b     = '0;
    first = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < BAUD; s++) begin
        if (i != 0 || s != 0) @(negedge clk);
        v = tx_a;
        if (s == 0) first = v;
        else if (v !== first) ok = 1'b0;
      end
      if (i == 0 && first !== 1'b0) ok = 1'b0;
      if (i == 9 && first !== 1'b1) ok = 1'b0;
      if (i >= 1 && i <= 8) b[i-1] = first;
    end
  endtask

  task automatic receive_message(input string tag, input int pulse_frame);
    logic [7:0] b;
    logic       ok;
    for (int f = 0; f < 12; f++) begin
      if (f > 0) @(negedge clk);
      grab_frame(b, ok);
      check_val($sformatf("%s_byte%0d", tag, f), b, msg[f]);
      check_val($sformatf("%s_frame%0d", tag, f), ok, 1);
      if (f == pulse_frame) sw[16] = 1'b1;
      if (f == pulse_frame + 1) sw[16] = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    logic saw_low;
    saw_low = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) saw_low = 1'b1;
    end
    check_val(tag, saw_low, 0);
  endtask

  task automatic wait_digit(input int d, output logic [7:0] s);
    logic [7:0] want;
    logic       found;
    want  = ~(8'd1 << d);
    found = 1'b0;
    s     = '0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (an === want) begin
        found = 1'b1;
        s     = seg;
      end
    end
    check_val($sformatf("digit%0d_found", d), found, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_a = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_a = stop;
    repeat (BAUD) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       ok;
    logic       found;
    logic       good;
    int         waited;
    logic [7:0] s;
    logic [7:0] segs [8];

    repeat (3) @(negedge clk);
    check_val("rst_tx_a", tx_a, 1);
    check_val("rst_tx_b", tx_b, 1);
    check_val("rst_tx_c", tx_c, 1);
    check_val("rst_an", an, 8'hFF);
    check_val("rst_seg", seg, 8'hFF);
    check_val("rst_leds", leds, 16'h0000);

    rst_n = 1'b1;
    wait_start(10, waited, found);
    check_val("boot_start_found", found, 1);
    check_val("boot_start_within_4", (waited <= 4), 1);
    receive_message("boot", -1);
    check_idle("boot_idle_after", 100);

    @(negedge clk);
    sw = 20'h0A5C3;
    @(negedge clk);
    @(negedge clk);
    check_val("leds_lat2", leds, 16'h0000);
    @(negedge clk);
    check_val("leds_lat3", leds, 16'hA5C3);
    wait_digit(1, s);
    check_val("sw_digit1", s, 8'hC6);
    wait_digit(0, s);
    check_val("sw_digit0", s, 8'hB0);

    send_rx(8'h3C, 1'b1);
    wait_digit(3, s);
    check_val("rx_digit3", s, 8'hB0);
    wait_digit(2, s);
    check_val("rx_digit2", s, 8'hC6);
    send_rx(8'h55, 1'b0);
    wait_digit(3, s);
    check_val("badstop_digit3", s, 8'hB0);
    wait_digit(2, s);
    check_val("badstop_digit2", s, 8'hC6);

    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (an === 8'h7F) found = 1'b1;
    end
    check_val("scan_find_7F", found, 1);
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (an === 8'hFE) found = 1'b1;
    end
    check_val("scan_find_FE", found, 1);
    for (int d = 0; d < 8; d++) begin
      good = 1'b1;
      for (int c = 0; c < REFRESH; c++) begin
        if (d != 0 || c != 0) @(negedge clk);
        if (an !== ~(8'd1 << d)) good = 1'b0;
        if (c == 0) segs[d] = seg;
      end
      check_val($sformatf("scan_an_d%0d", d), good, 1);
      check_val($sformatf("scan_seg_d%0d", d), segs[d], exp_seg[d]);
    end

    @(negedge clk);
    rx_b = 1'b0;
    @(negedge clk);
    check_val("lb_b_lat1", tx_b, 1);
    @(negedge clk);
    check_val("lb_b_lat2", tx_b, 0);
    check_val("lb_c_hold", tx_c, 1);
    rx_b = 1'b1;
    rx_c = 1'b0;
    @(negedge clk);
    check_val("lb_c_lat1", tx_c, 1);
    check_val("lb_b_hold", tx_b, 0);
    @(negedge clk);
    check_val("lb_c_lat2", tx_c, 0);
    check_val("lb_b_back", tx_b, 1);
    rx_c = 1'b1;
    repeat (4) @(negedge clk);

    sw[16] = 1'b1;
    wait_start(20, waited, found);
    sw[16] = 1'b0;
    check_val("replay_start_found", found, 1);
    receive_message("replay", 2);
    check_idle("replay_single_msg", 100);

    sw[16] = 1'b1;
    wait_start(20, waited, found);
    sw[16] = 1'b0;
    check_val("rst2_start_found", found, 1);
    grab_frame(b, ok);
    check_val("rst2_byte0", b, 8'h48);
    @(negedge clk);
    grab_frame(b, ok);
    check_val("rst2_byte1", b, 8'h4F);
    @(negedge clk);
    check_val("rst2_in_start_bit", tx_a, 0);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_mid_tx_a", tx_a, 1);
    check_val("rst_mid_an", an, 8'hFF);
    check_val("rst_mid_leds", leds, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(10, waited, found);
    check_val("rst_restart_found", found, 1);
    check_val("rst_restart_within_4", (waited <= 4), 1);
    grab_frame(b, ok);
    check_val("rst_restart_byte0", b, 8'h48);
    check_val("rst_restart_frame0", ok, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
